softex_tcdm_chan_arbiter: RTL and testbench
===========================================

// Module: softex_tcdm_chan_arbiter
// PURPOSE
// N-channel TCDM arbiter for the softex streamer; generalises the 2-channel out-of-order mux + FIFO + r_user filter chain.
// Round-robin (or forced-priority) arbitration of NB_CHAN load/store channels onto one TCDM port.
// Read responses are routed back through an internal in-order channel-ID tracker instead of user bits.
// Sits between the softex sources/sinks and the shared TCDM port of the streamer.
// PARAMETERS
// NB_CHAN          4    number of requesting channels (>=2)
// DW               288  data width in bits (multiple of 8)
// AW               32   address width
// MAX_OUTSTANDING  4    depth of read-ID tracker (power of 2, >=2)
// PORTS
// clk_i             in   1              clock
// rst_ni            in   1              asynchronous reset, active-low
// clear_i           in   1              synchronous flush of arbiter state and tracker
// enable_i          in   1              0: no new grants; responses still routed
// priority_force_i  in   1              1: fixed priority from priority_i instead of round-robin
// priority_i        in   $clog2(NB_CHAN) channel given priority when forced
// chan_req_i        in   NB_CHAN        per-channel request
// chan_gnt_o        out  NB_CHAN        per-channel grant
// chan_add_i        in   NB_CHAN*AW     per-channel address
// chan_wen_i        in   NB_CHAN        1 = read, 0 = write
// chan_be_i         in   NB_CHAN*DW/8   per-channel byte enables
// chan_data_i       in   NB_CHAN*DW     per-channel write data
// chan_r_valid_o    out  NB_CHAN        per-channel read response valid (one-hot or zero)
// chan_r_data_o     out  DW             read data, broadcast to all channels
// tcdm_req_o / tcdm_gnt_i / tcdm_add_o / tcdm_wen_o / tcdm_be_o / tcdm_data_o   TCDM request side (widths 1/1/AW/1/DW/8/DW)
// tcdm_r_valid_i    in   1              TCDM read response valid (reads only, in order)
// tcdm_r_data_i     in   DW             TCDM read data
// outstanding_o     out  $clog2(MAX_OUTSTANDING)+1  reads in flight
// err_o             out  1              sticky: r_valid received with empty tracker
// BEHAVIOUR
// - Reset (rst_ni=0): all outputs 0; rr pointer=0; tracker empty; err_o=0. clear_i=1 has the same effect next edge.
// - Request path combinational, zero latency: winner's add/wen/be/data muxed to tcdm_*; tcdm_req_o=|eligible req.
// - Eligible = chan_req_i & enable_i & ~(chan_wen_i & tracker_full_eff); tracker_full_eff = full and no pop this cycle.
// - Winner: forced -> priority_i if eligible, else lowest-index eligible above priority_i (wrapping);
//   round-robin -> first eligible at or after rr pointer (wrapping).
// - chan_gnt_o[w]=tcdm_gnt_i for winner only. On handshake rr pointer <= (w+1) mod NB_CHAN; unchanged when forced.
// - Granted read pushes w into tracker; writes never enter tracker and produce no response.
// - tcdm_r_valid_i pops tracker head h: chan_r_valid_o[h]=1 same cycle, chan_r_data_o=tcdm_r_data_i (combinational).
// - Push+pop same cycle: both performed, count unchanged; allowed when full (pop frees slot).
// - r_valid with empty tracker: dropped, chan_r_valid_o=0, err_o set until reset/clear.
// - Pointers wrap modulo MAX_OUTSTANDING; outstanding_o = push count - pop count, never exceeds MAX_OUTSTANDING.
// - enable_i=0 mid-stream: no new grants; in-flight reads still delivered.
// - clear_i mid-operation: tracker discarded; later stray r_valid sets err_o (caller must drain first).
// TESTING
// - 4 channels req reads continuously, gnt=1, r_valid 1 cycle later -> grants 0,1,2,3,0...; each r_valid to correct channel.
// - priority_force_i=1, priority_i=2, chans 1,2 req -> chan 2 granted every cycle; rr pointer frozen.
// - Hold tcdm_r_valid_i=0, ch0 issues 4 reads -> 5th read not granted, ch1 write still granted; outstanding_o=4.
// - Tracker full, r_valid and new read same cycle -> read granted, outstanding_o stays 4, IDs preserved in order.
// - r_valid with empty tracker -> all chan_r_valid_o=0, err_o=1 until clear_i pulse -> err_o=0.
// - Async reset asserted with 3 reads outstanding -> outputs 0 immediately, outstanding_o=0, grants restart at chan 0.

Source files
------------

// File: rtl/softex_tcdm_chan_arbiter.sv
// -----------------------------------------------------------------------------
// softex_tcdm_chan_arbiter
//
// Arbitrates NB_CHAN load/store channels of the softex streamer onto a single
// TCDM port. The winner is chosen round-robin, or by a forced priority when
// priority_force_i is set. Read responses return in order on the TCDM side.
// A small in-order tracker of channel IDs steers each response back to the
// channel that issued the read, so no user bits travel through the TCDM.
//
// Ports
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   clear_i                synchronous flush of rr pointer, tracker and error
//   enable_i               0 blocks new grants; responses are still routed
//   priority_force_i       1 selects fixed priority starting at priority_i
//   priority_i             channel favoured while priority is forced
//   chan_req_i/gnt_o       per-channel request / grant
//   chan_add_i/wen_i/be_i/data_i  per-channel request payload (wen 1 = read)
//   chan_r_valid_o         one-hot (or zero) read response valid
//   chan_r_data_o          read data, broadcast to every channel
//   tcdm_*                 shared TCDM request and response port
//   outstanding_o          number of reads in flight
//   err_o                  sticky: response arrived with an empty tracker
// -----------------------------------------------------------------------------
module softex_tcdm_chan_arbiter #(
  parameter int NB_CHAN         = 4,
  parameter int DW              = 288,
  parameter int AW              = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_ni,
  input  logic                                 clear_i,
  input  logic                                 enable_i,
  input  logic                                 priority_force_i,
  input  logic [$clog2(NB_CHAN)-1:0]           priority_i,
  input  logic [NB_CHAN-1:0]                   chan_req_i,
  output logic [NB_CHAN-1:0]                   chan_gnt_o,
  input  logic [NB_CHAN*AW-1:0]                chan_add_i,
  input  logic [NB_CHAN-1:0]                   chan_wen_i,
  input  logic [NB_CHAN*DW/8-1:0]              chan_be_i,
  input  logic [NB_CHAN*DW-1:0]                chan_data_i,
  output logic [NB_CHAN-1:0]                   chan_r_valid_o,
  output logic [DW-1:0]                        chan_r_data_o,
  output logic                                 tcdm_req_o,
  input  logic                                 tcdm_gnt_i,
  output logic [AW-1:0]                        tcdm_add_o,
  output logic                                 tcdm_wen_o,
  output logic [DW/8-1:0]                      tcdm_be_o,
  output logic [DW-1:0]                        tcdm_data_o,
  input  logic                                 tcdm_r_valid_i,
  input  logic [DW-1:0]                        tcdm_r_data_i,
  output logic [$clog2(MAX_OUTSTANDING):0]     outstanding_o,
  output logic                                 err_o
);

  localparam int CW = $clog2(NB_CHAN);
  localparam int PW = $clog2(MAX_OUTSTANDING);
  localparam int OW = PW + 1;
  localparam int BW = DW / 8;

  // Decode a channel index into a one-hot channel mask.
  function automatic logic [NB_CHAN-1:0] chan_onehot(input logic [CW-1:0] id);
    logic [NB_CHAN-1:0] oh;
    for (int c = 0; c < NB_CHAN; c++) begin
      oh[c] = (id == CW'(c));
    end
    return oh;
  endfunction

  // State
  logic [CW-1:0] rr_ptr_r;
  logic [CW-1:0] id_mem_r [MAX_OUTSTANDING];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [OW-1:0] count_r;
  logic          err_r;

  // Combinational
  logic [NB_CHAN-1:0] eligible_s;
  logic [NB_CHAN-1:0] win_oh_s;
  logic [CW-1:0]      start_s;
  logic [CW-1:0]      idx_s;
  logic [CW-1:0]      win_s;
  logic [CW-1:0]      rr_next_s;
  logic [CW-1:0]      head_s;
  logic               found_s;
  logic               handshake_s;
  logic               push_s;
  logic               pop_s;
  logic               empty_s;
  logic               full_s;
  logic               full_eff_s;
  logic [OW-1:0]      count_next_s;

  // Tracker status. A pop in the same cycle frees a slot, so a full tracker
  // still accepts a new read when a response is being consumed.
  always_comb begin
    empty_s    = (count_r == {OW{1'b0}});
    full_s     = (count_r == OW'(MAX_OUTSTANDING));
    pop_s      = tcdm_r_valid_i & ~empty_s & rst_ni;
    full_eff_s = full_s & ~pop_s;
    head_s     = id_mem_r[rd_ptr_r];
  end

  // Eligibility: reads are held back while the tracker cannot take another ID.
  // Gating with rst_ni keeps every request-side output quiet during reset.
  always_comb begin
    eligible_s = chan_req_i
               & {NB_CHAN{enable_i}}
               & {NB_CHAN{rst_ni}}
               & ~(chan_wen_i & {NB_CHAN{full_eff_s}});
  end

  // Search start: forced priority channel or round-robin pointer.
  always_comb begin
    if (priority_force_i) begin
      start_s = priority_i;
    end else begin
      start_s = rr_ptr_r;
    end
  end

  // Winner: first eligible channel at or after start_s, wrapping around.
  // Forced priority uses the same search, which picks priority_i when it is
  // eligible and otherwise the next eligible channel above it.
  always_comb begin
    found_s = 1'b0;
    win_s   = {CW{1'b0}};
    idx_s   = {CW{1'b0}};
    for (int k = 0; k < NB_CHAN; k++) begin
      idx_s = CW'((int'(start_s) + k) % NB_CHAN);
      if (!found_s && eligible_s[idx_s]) begin
        found_s = 1'b1;
        win_s   = idx_s;
      end else begin
        found_s = found_s;
      end
    end
  end

  // Grant and handshake qualification.
  always_comb begin
    if (found_s) begin
      win_oh_s = chan_onehot(win_s);
    end else begin
      win_oh_s = {NB_CHAN{1'b0}};
    end
    tcdm_req_o  = found_s;
    handshake_s = found_s & tcdm_gnt_i;
    chan_gnt_o  = win_oh_s & {NB_CHAN{tcdm_gnt_i}};
    push_s      = handshake_s & (|(win_oh_s & chan_wen_i));
  end

  // Request payload mux: AND-OR over the one-hot winner, zero when idle.
  always_comb begin
    tcdm_add_o  = {AW{1'b0}};
    tcdm_wen_o  = 1'b0;
    tcdm_be_o   = {BW{1'b0}};
    tcdm_data_o = {DW{1'b0}};
    for (int c = 0; c < NB_CHAN; c++) begin
      tcdm_add_o  = tcdm_add_o  | (chan_add_i[c*AW +: AW]  & {AW{win_oh_s[c]}});
      tcdm_wen_o  = tcdm_wen_o  | (chan_wen_i[c]           &      win_oh_s[c]);
      tcdm_be_o   = tcdm_be_o   | (chan_be_i[c*BW +: BW]   & {BW{win_oh_s[c]}});
      tcdm_data_o = tcdm_data_o | (chan_data_i[c*DW +: DW] & {DW{win_oh_s[c]}});
    end
  end

  // Response routing: the tracker head names the channel owning this beat.
  always_comb begin
    if (pop_s) begin
      chan_r_valid_o = chan_onehot(head_s);
    end else begin
      chan_r_valid_o = {NB_CHAN{1'b0}};
    end
    chan_r_data_o = tcdm_r_data_i & {DW{rst_ni}};
  end

  // Next round-robin pointer: one past the winner, frozen while forced.
  always_comb begin
    if (handshake_s && !priority_force_i) begin
      if (win_s == CW'(NB_CHAN - 1)) begin
        rr_next_s = {CW{1'b0}};
      end else begin
        rr_next_s = win_s + CW'(1);
      end
    end else begin
      rr_next_s = rr_ptr_r;
    end
  end

  // Next occupancy; simultaneous push and pop leave it unchanged.
  always_comb begin
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + OW'(1);
      2'b01:   count_next_s = count_r - OW'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Round-robin pointer register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rr_ptr_r <= {CW{1'b0}};
    end else if (clear_i) begin
      rr_ptr_r <= {CW{1'b0}};
    end else begin
      rr_ptr_r <= rr_next_s;
    end
  end

  // Tracker pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {OW{1'b0}};
    end else if (clear_i) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {OW{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      count_r <= count_next_s;
    end
  end

  // Tracker ID storage: the granted read's channel goes in at the write pointer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_mem_r[i] <= {CW{1'b0}};
      end
    end else if (clear_i) begin
      for (int i = 0; i < MAX_OUTSTANDING; i++) begin
        id_mem_r[i] <= {CW{1'b0}};
      end
    end else if (push_s) begin
      id_mem_r[wr_ptr_r] <= win_s;
    end
  end

  // Sticky error: a response with nothing outstanding is dropped and flagged.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      err_r <= 1'b0;
    end else if (clear_i) begin
      err_r <= 1'b0;
    end else if (tcdm_r_valid_i && empty_s) begin
      err_r <= 1'b1;
    end
  end

  assign outstanding_o = count_r;
  assign err_o         = err_r;

endmodule

// File: tb/tb_softex_tcdm_chan_arbiter.sv
module tb_softex_tcdm_chan_arbiter;

  localparam int NB  = 4;
  localparam int DW  = 288;
  localparam int AW  = 32;
  localparam int MO  = 4;
  localparam int CW  = 2;

  logic                 clk = 1'b0;
  logic                 rst_ni;
  logic                 clear_i;
  logic                 enable_i;
  logic                 priority_force_i;
  logic [CW-1:0]        priority_i;
  logic [NB-1:0]        chan_req_i;
  logic [NB-1:0]        chan_gnt_o;
  logic [NB*AW-1:0]     chan_add_i;
  logic [NB-1:0]        chan_wen_i;
  logic [NB*DW/8-1:0]   chan_be_i;
  logic [NB*DW-1:0]     chan_data_i;
  logic [NB-1:0]        chan_r_valid_o;
  logic [DW-1:0]        chan_r_data_o;
  logic                 tcdm_req_o;
  logic                 tcdm_gnt_i;
  logic [AW-1:0]        tcdm_add_o;
  logic                 tcdm_wen_o;
  logic [DW/8-1:0]      tcdm_be_o;
  logic [DW-1:0]        tcdm_data_o;
  logic                 tcdm_r_valid_i;
  logic [DW-1:0]        tcdm_r_data_i;
  logic [$clog2(MO):0]  outstanding_o;
  logic                 err_o;

  int n_checks = 0;
  int n_errors = 0;
  int sb_q[$];

  softex_tcdm_chan_arbiter #(
    .NB_CHAN(NB), .DW(DW), .AW(AW), .MAX_OUTSTANDING(MO)
  ) dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .clear_i          (clear_i),
    .enable_i         (enable_i),
    .priority_force_i (priority_force_i),
    .priority_i       (priority_i),
    .chan_req_i       (chan_req_i),
    .chan_gnt_o       (chan_gnt_o),
    .chan_add_i       (chan_add_i),
    .chan_wen_i       (chan_wen_i),
    .chan_be_i        (chan_be_i),
    .chan_data_i      (chan_data_i),
    .chan_r_valid_o   (chan_r_valid_o),
    .chan_r_data_o    (chan_r_data_o),
    .tcdm_req_o       (tcdm_req_o),
    .tcdm_gnt_i       (tcdm_gnt_i),
    .tcdm_add_o       (tcdm_add_o),
    .tcdm_wen_o       (tcdm_wen_o),
    .tcdm_be_o        (tcdm_be_o),
    .tcdm_data_o      (tcdm_data_o),
    .tcdm_r_valid_i   (tcdm_r_valid_i),
    .tcdm_r_data_i    (tcdm_r_data_i),
    .outstanding_o    (outstanding_o),
    .err_o            (err_o)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive request and response inputs, then let combinational paths settle.
  task automatic drive(input logic [NB-1:0] req, input logic [NB-1:0] wen, input logic rv);
    chan_req_i     = req;
    chan_wen_i     = wen;
    tcdm_r_valid_i = rv;
    tcdm_r_data_i  = {9{$urandom()}};
    #2;
  endtask

  // Pop the expected owner of the current response and compare routing.
  task automatic expect_resp(input string tag);
    int id;
    if (sb_q.size() == 0) begin
      check_val({tag, "_sb_empty"}, 1, 0);
    end else begin
      id = sb_q.pop_front();
      check_val({tag, "_rvalid"}, chan_r_valid_o, 4'b0001 << id);
      check_val({tag, "_rdata"},  chan_r_data_o,  tcdm_r_data_i);
    end
  endtask

  initial begin
    logic [AW-1:0] exp_add;
    int rr_m;

    for (int c = 0; c < NB; c++) begin
      chan_add_i[c*AW +: AW]    = 32'h1000 + 32'(c * 16);
      chan_data_i[c*DW +: DW]   = {9{32'hA0 + 32'(c)}};
    end
    chan_be_i        = '1;
    rst_ni           = 1'b0;
    clear_i          = 1'b0;
    enable_i         = 1'b1;
    priority_force_i = 1'b0;
    priority_i       = 2'd0;
    tcdm_gnt_i       = 1'b1;
    drive(4'hF, 4'hF, 1'b0);

    // Reset state with requests pending
    check_val("rst_gnt", chan_gnt_o, 0);
    check_val("rst_req", tcdm_req_o, 0);
    check_val("rst_out", outstanding_o, 0);
    check_val("rst_err", err_o, 0);
    tick();
    rst_ni = 1'b1;

    // Round robin reads, response one cycle after each grant
    rr_m = 0;
    for (int i = 0; i < 8; i++) begin
      drive(4'hF, 4'hF, i > 0);
      if (i > 0) expect_resp("rr");
      check_val("rr_gnt", chan_gnt_o, 4'b0001 << rr_m);
      exp_add = 32'h1000 + 32'(rr_m * 16);
      check_val("rr_add", tcdm_add_o, exp_add);
      check_val("rr_out", outstanding_o, (i > 0) ? 1 : 0);
      sb_q.push_back(rr_m);
      rr_m = (rr_m + 1) % NB;
      tick();
    end
    drive(4'h0, 4'h0, 1'b1);
    expect_resp("rr_drain");
    check_val("rr_idle_req", tcdm_req_o, 0);
    tick();
    drive(4'h0, 4'h0, 1'b0);
    check_val("rr_drain_out", outstanding_o, 0);

    // Forced priority, writes only; rr pointer must stay at 0
    priority_force_i = 1'b1;
    priority_i       = 2'd2;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0110, 4'b0000, 1'b0);
      check_val("frc_gnt", chan_gnt_o, 4'b0100);
      tick();
    end
    drive(4'b0011, 4'b0000, 1'b0);
    check_val("frc_wrap_gnt", chan_gnt_o, 4'b0001);
    tick();
    priority_force_i = 1'b0;
    drive(4'hF, 4'h0, 1'b0);
    check_val("frc_rr_frozen", chan_gnt_o, 4'b0001);
    check_val("frc_wr_wen", tcdm_wen_o, 0);
    tick();
    drive(4'hF, 4'h0, 1'b0);
    check_val("frc_rr_next", chan_gnt_o, 4'b0010);
    check_val("wr_no_track", outstanding_o, 0);
    tick();

    // Fill tracker with four ch0 reads, no responses
    for (int i = 0; i < 4; i++) begin
      drive(4'b0001, 4'b0001, 1'b0);
      check_val("fill_gnt", chan_gnt_o, 4'b0001);
      sb_q.push_back(0);
      tick();
    end
    drive(4'b0001, 4'b0001, 1'b0);
    check_val("full_out", outstanding_o, 4);
    check_val("full_blk_req", tcdm_req_o, 0);
    check_val("full_blk_gnt", chan_gnt_o, 0);
    tick();
    drive(4'b0011, 4'b0001, 1'b0);
    check_val("full_wr_gnt", chan_gnt_o, 4'b0010);
    check_val("full_wr_add", tcdm_add_o, 32'h1010);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    check_val("full_out2", outstanding_o, 4);

    // Full tracker: pop and push in the same cycle
    drive(4'b1000, 4'b1000, 1'b1);
    check_val("swap_gnt3", chan_gnt_o, 4'b1000);
    expect_resp("swap3");
    sb_q.push_back(3);
    tick();
    drive(4'b0100, 4'b0100, 1'b1);
    check_val("swap_out", outstanding_o, 4);
    check_val("swap_gnt2", chan_gnt_o, 4'b0100);
    expect_resp("swap2");
    sb_q.push_back(2);
    tick();
    for (int i = 0; i < 4; i++) begin
      drive(4'b0000, 4'b0000, 1'b1);
      check_val("drain_out", outstanding_o, 4 - i);
      expect_resp("drain");
      tick();
    end
    drive(4'b0000, 4'b0000, 1'b0);
    check_val("drain_empty", outstanding_o, 0);

    // Stray response with empty tracker
    drive(4'b0000, 4'b0000, 1'b1);
    check_val("stray_rvalid", chan_r_valid_o, 0);
    tick();
    drive(4'b0000, 4'b0000, 1'b0);
    check_val("stray_err", err_o, 1);
    tick();
    check_val("stray_err_sticky", err_o, 1);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    #2;
    check_val("clr_err", err_o, 0);

    // Three reads in flight, then asynchronous reset mid-cycle
    for (int i = 0; i < 3; i++) begin
      drive(4'hF, 4'hF, 1'b0);
      check_val("pre_rst_gnt", chan_gnt_o, 4'b0001 << i);
      tick();
    end
    drive(4'hF, 4'hF, 1'b1);
    check_val("pre_rst_out", outstanding_o, 3);
    rst_ni = 1'b0;
    #1;
    check_val("arst_gnt", chan_gnt_o, 0);
    check_val("arst_req", tcdm_req_o, 0);
    check_val("arst_out", outstanding_o, 0);
    check_val("arst_rvalid", chan_r_valid_o, 0);
    check_val("arst_rdata", chan_r_data_o, 0);
    tick();
    rst_ni = 1'b1;
    sb_q.delete();
    drive(4'hF, 4'hF, 1'b0);
    check_val("arst_restart", chan_gnt_o, 4'b0001);
    check_val("arst_err", err_o, 0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
